// File: rtl/mole_game_if.sv
// Whack-a-mole game bus: player controls in, mole/score/countdown status out.
interface mole_game_if #(
  parameter int POS_W   = 3,
  parameter int SCORE_W = 8
);
  logic               i_start;
  logic               i_eval;
  logic [POS_W-1:0]   i_guess;
  logic [POS_W-1:0]   o_mole_pos;
  logic               o_mole_change;
  logic               o_hit;
  logic               o_miss;
  logic               o_timeout;
  logic [SCORE_W-1:0] o_score;
  logic [4:0]         o_seconds;
  logic [1:0]         o_state;
  logic               o_game_over;

  // Input side (debouncers / bench) drives the controls.
  modport master (
    output i_start, i_eval, i_guess,
    input  o_mole_pos, o_mole_change, o_hit, o_miss, o_timeout,
           o_score, o_seconds, o_state, o_game_over
  );

  // Game core consumes controls and drives status.
  modport slave (
    input  i_start, i_eval, i_guess,
    output o_mole_pos, o_mole_change, o_hit, o_miss, o_timeout,
           o_score, o_seconds, o_state, o_game_over
  );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game core: LFSR mole placement, guess scoring, mole timeout,
// countdown and IDLE/PLAY/OVER game FSM.
module mole_game_ctrl #(
  parameter int          NUM_HOLES          = 8,
  parameter int          POS_W              = 3,
  parameter int          SCORE_W            = 8,
  parameter int          GAME_SECONDS       = 30,
  parameter int          TICKS_PER_SEC      = 100_000_000,
  parameter int          MOLE_TIMEOUT_TICKS = 150_000_000,
  parameter bit          MISS_PENALTY       = 1'b0,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  mole_game_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_e;

  localparam int TW = $clog2(TICKS_PER_SEC + 1);
  localparam int MW = $clog2(MOLE_TIMEOUT_TICKS + 1);
  // Candidate arithmetic is done wide enough for both the 8-bit LFSR slice and the position.
  localparam int CW = (POS_W > 9) ? POS_W : 9;

  localparam logic [TW-1:0]      TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [MW-1:0]      TMO_LAST  = MW'(MOLE_TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0]      HOLES     = CW'(NUM_HOLES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [4:0]         SEC_INIT  = 5'(GAME_SECONDS);

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q;
  logic [POS_W-1:0]   pos_q;
  logic [SCORE_W-1:0] score_q;
  logic [4:0]         sec_q;
  logic [TW-1:0]      tick_q;
  logic [MW-1:0]      tmo_q;
  logic               hit_pend_q;
  logic               hit_q, miss_q, tmo_pulse_q, chg_q;

  logic               play, start_game, wrap, final_tick;
  logic               eval_hit, eval_miss, tmo_fire, move_play;
  logic [CW-1:0]      cand, new_pos_ext;
  logic [POS_W-1:0]   new_pos;

  // Game FSM next state plus the per-cycle event decode that drives the datapath.
  always_comb begin
    state_d     = state_q;
    play        = (state_q == PLAY);
    start_game  = bus.i_start && (state_q == IDLE || state_q == OVER);
    wrap        = play && (tick_q == TICK_LAST);
    final_tick  = wrap && (sec_q == 5'd1);
    eval_hit    = play && bus.i_eval && (bus.i_guess == pos_q);
    eval_miss   = play && bus.i_eval && (bus.i_guess != pos_q);
    // A scheduled hit move takes priority, so the timeout cannot also fire that cycle.
    tmo_fire    = play && !hit_pend_q && (tmo_q == TMO_LAST);
    move_play   = play && (hit_pend_q || tmo_fire);
    cand        = CW'(lfsr_q[7:0]) % HOLES;
    new_pos_ext = cand;
    if (cand == CW'(pos_q))
      new_pos_ext = (cand == HOLES - CW'(1)) ? '0 : cand + CW'(1);
    new_pos     = POS_W'(new_pos_ext);
    case (state_q)
      IDLE:    if (bus.i_start) state_d = PLAY;
      PLAY:    if (final_tick)  state_d = OVER;
      OVER:    if (bus.i_start) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // State register, LFSR, counters, score, mole position and output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      pos_q       <= '0;
      score_q     <= '0;
      sec_q       <= SEC_INIT;
      tick_q      <= '0;
      tmo_q       <= '0;
      hit_pend_q  <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      tmo_pulse_q <= 1'b0;
      chg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      hit_q       <= eval_hit;
      miss_q      <= eval_miss;
      tmo_pulse_q <= tmo_fire;
      chg_q       <= start_game || move_play;
      // No follow-up move once the game has ended on this edge.
      hit_pend_q  <= eval_hit && !final_tick;
      if (start_game || move_play) pos_q <= new_pos;
      if (start_game) begin
        score_q <= '0;
        sec_q   <= SEC_INIT;
        tick_q  <= '0;
        tmo_q   <= '0;
      end else if (play) begin
        tick_q <= wrap ? '0 : tick_q + TW'(1);
        if (wrap) sec_q <= sec_q - 5'd1;
        if (eval_hit && score_q != SCORE_MAX)
          score_q <= score_q + SCORE_W'(1);
        else if (eval_miss && MISS_PENALTY && score_q != '0)
          score_q <= score_q - SCORE_W'(1);
        tmo_q <= (eval_hit || move_play) ? '0 : tmo_q + MW'(1);
      end
    end
  end

  assign bus.o_mole_pos    = pos_q;
  assign bus.o_mole_change = chg_q;
  assign bus.o_hit         = hit_q;
  assign bus.o_miss        = miss_q;
  assign bus.o_timeout     = tmo_pulse_q;
  assign bus.o_score       = score_q;
  assign bus.o_seconds     = sec_q;
  assign bus.o_state       = state_q;
  assign bus.o_game_over   = (state_q == OVER);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: scoreboard of guess results, LFSR-based mole
// position model, directed countdown/timeout/saturation/reset scenarios.
module tb_mole_game_ctrl;
  localparam int NH = 5;
  localparam int PW = 3;
  localparam int SW = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mole_game_if #(.POS_W(PW), .SCORE_W(SW)) bus ();

  mole_game_ctrl #(
    .NUM_HOLES(NH), .POS_W(PW), .SCORE_W(SW), .GAME_SECONDS(3),
    .TICKS_PER_SEC(4), .MOLE_TIMEOUT_TICKS(10), .MISS_PENALTY(1'b1),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Reference LFSR; lfsr_prev holds the value the DUT used on the latest edge.
  logic [15:0] m_lfsr, lfsr_prev;
  always @(posedge clk) begin
    lfsr_prev <= m_lfsr;
    m_lfsr    <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct packed {
    logic          hit;
    logic          miss;
    logic [SW-1:0] score;
  } res_t;
  res_t sb[$];

  int m_pos = 0, m_score = 0, cyc = 0;
  int n_pulse = 0, n_chg = 0;
  int hit_cyc = -100, chg_cyc = -100, tmo_cyc = -100;

  function automatic int next_pos(input logic [15:0] l, input int p);
    int c;
    c = int'(l[7:0]) % NH;
    return (c == p) ? (c + 1) % NH : c;
  endfunction

  // Monitor: sample just after each edge, pop results, check every mole move.
  always @(posedge clk) begin
    res_t e;
    int   exp_p;
    #1;
    cyc++;
    if (rst) begin
      m_pos = 0;
      m_score = 0;
      sb.delete();
    end else begin
      if (bus.o_hit || bus.o_miss || bus.o_timeout || bus.o_mole_change) n_pulse++;
      if (bus.o_hit || bus.o_miss) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result_hit", bus.o_hit, e.hit);
          chk("result_miss", bus.o_miss, e.miss);
          chk("result_score", bus.o_score, e.score);
        end
        if (bus.o_hit) hit_cyc = cyc;
      end
      if (bus.o_mole_change) begin
        exp_p = next_pos(lfsr_prev, m_pos);
        chk("mole_pos", bus.o_mole_pos, exp_p);
        chk("mole_moved", int'(int'(bus.o_mole_pos) != m_pos), 1);
        chk("mole_in_range", int'(int'(bus.o_mole_pos) < NH), 1);
        m_pos = exp_p;
        chg_cyc = cyc;
        n_chg++;
      end
      if (bus.o_timeout) begin
        chk("timeout_with_change", bus.o_mole_change, 1);
        tmo_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    m_score = 0;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Drive one evaluated guess and push the result the DUT must produce.
  task automatic do_eval(input int g);
    res_t e;
    bit   hit;
    logic [31:0] gv;
    hit = (g == m_pos);
    if (hit) m_score = (m_score == SMAX) ? SMAX : m_score + 1;
    else     m_score = (m_score == 0) ? 0 : m_score - 1;
    e.hit   = hit;
    e.miss  = !hit;
    e.score = SW'(m_score);
    sb.push_back(e);
    gv = g;
    bus.i_guess = gv[PW-1:0];
    bus.i_eval  = 1'b1;
    @(negedge clk);
    bus.i_eval  = 1'b0;
  endtask

  task automatic wait_over(input int max);
    int k;
    k = 0;
    while (!bus.o_game_over && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("game_over_reached", bus.o_game_over, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int s, np, nc;
    logic [31:0] gv;
    bus.i_start = 1'b0;
    bus.i_eval  = 1'b0;
    bus.i_guess = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("rst_state", bus.o_state, 0);
    chk("rst_seconds", bus.o_seconds, 3);
    chk("rst_score", bus.o_score, 0);
    chk("rst_pos", bus.o_mole_pos, 0);
    chk("rst_over", bus.o_game_over, 0);
    tick(20);
    chk("idle_state", bus.o_state, 0);
    chk("idle_seconds", bus.o_seconds, 3);
    chk("idle_score", bus.o_score, 0);
    chk("idle_pulses", n_pulse, 0);

    // Game A: hit, move latency, misses with penalty floored at 0, then OVER.
    pulse_start;
    chk("start_state", bus.o_state, 1);
    chk("start_seconds", bus.o_seconds, 3);
    chk("start_change", chg_cyc, cyc);
    do_eval(m_pos);
    tick(1);
    chk("hit_move_latency", chg_cyc - hit_cyc, 1);
    do_eval((m_pos + 1) % NH);
    do_eval(7);
    wait_over(20);
    chk("over_state", bus.o_state, 2);
    chk("over_seconds", bus.o_seconds, 0);
    chk("over_score", bus.o_score, 0);
    np = n_pulse;
    gv = m_pos;
    bus.i_guess = gv[PW-1:0];
    bus.i_eval = 1'b1;
    tick(1);
    bus.i_eval = 1'b0;
    tick(3);
    chk("over_eval_ignored", n_pulse - np, 0);
    chk("over_score_frozen", bus.o_score, 0);

    // Game B: untouched countdown and mole timeout.
    pulse_start;
    s = cyc;
    chk("restart_state", bus.o_state, 1);
    chk("restart_seconds", bus.o_seconds, 3);
    chk("restart_score", bus.o_score, 0);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k % 4 == 0 && k < 12) chk("countdown", bus.o_seconds, 3 - k / 4);
    end
    chk("final_state", bus.o_state, 2);
    chk("final_seconds", bus.o_seconds, 0);
    chk("final_game_over", bus.o_game_over, 1);
    chk("timeout_cycle", tmo_cyc - s, 10);
    chk("timeout_score", bus.o_score, 0);

    // Game C: saturating score, then a miss on the final tick lands in OVER.
    pulse_start;
    repeat (5) begin
      do_eval(m_pos);
      tick(1);
    end
    chk("sat_score", bus.o_score, SMAX);
    tick(1);
    do_eval((m_pos + 1) % NH);
    chk("late_eval_state", bus.o_state, 2);
    chk("late_eval_score", bus.o_score, 2);
    nc = n_chg;
    tick(4);
    chk("over_pos_frozen", n_chg - nc, 0);
    chk("over_score_kept", bus.o_score, 2);
    chk("sb_drained", sb.size(), 0);

    // Game D: reset in the middle of play.
    pulse_start;
    do_eval(m_pos);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_state", bus.o_state, 0);
    chk("midrst_score", bus.o_score, 0);
    chk("midrst_seconds", bus.o_seconds, 3);
    chk("midrst_pos", bus.o_mole_pos, 0);
    chk("midrst_pulses", int'(bus.o_hit | bus.o_miss | bus.o_timeout | bus.o_mole_change), 0);
    rst = 1'b0;
    tick(2);
    chk("post_rst_state", bus.o_state, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
